// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the fabric UART receiver.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK_WAIT
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fabric_if.sv
// Byte stream from the UART receiver to the CRC datapath (valid/ready).
interface uart_rx_fabric_if;

    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_READY;

    modport master (output RX_DATA, output RX_VALID, input RX_READY);
    modport slave  (input RX_DATA, input RX_VALID, output RX_READY);

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one tick every BAUD_DIV cycles, restartable so the
// sample phase is locked to the detected start edge.
module uart_baud_tick #(
    parameter int BAUD_DIV = 5,
    parameter int DIV_W    = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic tick_o
);

    logic [DIV_W-1:0] cnt_q;

    assign tick_o = (cnt_q == DIV_W'(BAUD_DIV - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || restart_i || tick_o)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: rtl/uart_rx_fabric.sv
// 8N1 (optional parity) UART receiver with 16x oversampling, start-glitch
// rejection and frame/parity/overrun error pulses.
module uart_rx_fabric
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = 5,
    parameter int DIV_W      = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic              SYSCLK,
    input  logic              SYSRESET,
    input  logic              RXD,
    uart_rx_fabric_if.master  rx_if,
    output logic              FRAME_ERR,
    output logic              PARITY_ERR,
    output logic              OVERRUN_ERR,
    output logic              BUSY
);

    localparam logic ODD = (PARITY_ODD != 0);

    rx_state_e  state_q, state_d;
    logic       rxd_s1_q, rxd_s2_q;
    logic       tick, restart, mid_bit;
    logic [3:0] tcnt_q, tcnt_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic [7:0] shift_q, shift_d;
    logic       perr_flag_q, perr_flag_d;
    logic       cmpl_q, cmpl_d;
    logic       ferr_q, ferr_d;
    logic       perr_pls_q, perr_pls_d;
    logic       ovr_q;
    logic [7:0] data_q;
    logic       valid_q;

    uart_baud_tick #(.BAUD_DIV(BAUD_DIV), .DIV_W(DIV_W)) u_tick (
        .clk_i     (SYSCLK),
        .rst_i     (SYSRESET),
        .restart_i (restart),
        .tick_o    (tick)
    );

    // Synchroniser resets to the idle line level so reset never looks like a start edge.
    always_ff @(posedge SYSCLK) begin
        if (SYSRESET) begin
            rxd_s1_q <= 1'b1;
            rxd_s2_q <= 1'b1;
        end else begin
            rxd_s1_q <= RXD;
            rxd_s2_q <= rxd_s1_q;
        end
    end

    assign mid_bit = tick && (tcnt_q == 4'(OVERSAMPLE - 1));

    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        bcnt_d      = bcnt_q;
        shift_d     = shift_q;
        perr_flag_d = perr_flag_q;
        cmpl_d      = 1'b0;
        ferr_d      = 1'b0;
        perr_pls_d  = 1'b0;
        restart     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!rxd_s2_q) begin
                    state_d     = ST_START;
                    tcnt_d      = '0;
                    perr_flag_d = 1'b0;
                    restart     = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (tcnt_q == 4'(MID_TICK)) begin
                        tcnt_d  = '0;
                        bcnt_d  = '0;
                        state_d = rxd_s2_q ? ST_IDLE : ST_DATA;
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
            end
            ST_DATA, ST_PARITY, ST_STOP: begin
                // 4-bit counter wraps 15 -> 0, landing each sample one bit later.
                if (tick)
                    tcnt_d = tcnt_q + 4'd1;
                if (mid_bit) begin
                    if (state_q == ST_DATA) begin
                        shift_d = {rxd_s2_q, shift_q[7:1]};
                        bcnt_d  = bcnt_q + 3'd1;
                        if (bcnt_q == 3'(DATA_BITS - 1))
                            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else if (state_q == ST_PARITY) begin
                        perr_flag_d = ((^shift_q) ^ rxd_s2_q) != ODD;
                        state_d     = ST_STOP;
                    end else if (!rxd_s2_q) begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK_WAIT;
                    end else begin
                        perr_pls_d = perr_flag_q;
                        cmpl_d     = !perr_flag_q;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_BREAK_WAIT: begin
                if (rxd_s2_q)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge SYSCLK) begin
        if (SYSRESET) begin
            state_q     <= ST_IDLE;
            tcnt_q      <= '0;
            bcnt_q      <= '0;
            shift_q     <= '0;
            perr_flag_q <= 1'b0;
            cmpl_q      <= 1'b0;
            ferr_q      <= 1'b0;
            perr_pls_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            bcnt_q      <= bcnt_d;
            shift_q     <= shift_d;
            perr_flag_q <= perr_flag_d;
            cmpl_q      <= cmpl_d;
            ferr_q      <= ferr_d;
            perr_pls_q  <= perr_pls_d;
        end
    end

    // Holding register: a completed byte loads only if the slot is free or being drained.
    always_ff @(posedge SYSCLK) begin
        if (SYSRESET) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (cmpl_q) begin
                if (!valid_q || rx_if.RX_READY) begin
                    data_q  <= shift_q;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (rx_if.RX_READY) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_if.RX_DATA  = data_q;
    assign rx_if.RX_VALID = valid_q;
    assign FRAME_ERR      = ferr_q;
    assign PARITY_ERR     = perr_pls_q;
    assign OVERRUN_ERR    = ovr_q;
    assign BUSY           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fabric.sv
// Bench for uart_rx_fabric: dut0 is 8N1, dut1 has even parity; frames are scored
// against a frame-level outcome model and a one-slot holding model.
module tb_uart_rx_fabric;

    localparam int BIT_CYC = 80;

    logic SYSCLK   = 1'b0;
    logic SYSRESET = 1'b1;
    logic rxd0 = 1'b1, rxd1 = 1'b1;
    logic ferr0, perr0, ovr0, busy0;
    logic ferr1, perr1, ovr1, busy1;

    uart_rx_fabric_if if0 ();
    uart_rx_fabric_if if1 ();

    uart_rx_fabric #(.BAUD_DIV(5), .DIV_W(16), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .SYSCLK(SYSCLK), .SYSRESET(SYSRESET), .RXD(rxd0), .rx_if(if0),
        .FRAME_ERR(ferr0), .PARITY_ERR(perr0), .OVERRUN_ERR(ovr0), .BUSY(busy0)
    );

    uart_rx_fabric #(.BAUD_DIV(5), .DIV_W(16), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .SYSCLK(SYSCLK), .SYSRESET(SYSRESET), .RXD(rxd1), .rx_if(if1),
        .FRAME_ERR(ferr1), .PARITY_ERR(perr1), .OVERRUN_ERR(ovr1), .BUSY(busy1)
    );

    always #5 SYSCLK = ~SYSCLK;

    int cyc = 0;
    always @(posedge SYSCLK) cyc <= cyc + 1;

    int n_tests = 0, n_fail = 0;
    logic [7:0] got0[$], got1[$], exp0[$], exp1[$];
    int fe_n[2], pe_n[2], ov_n[2], efe[2], epe[2], eov[2];
    bit held[2];
    int vhi0 = 0, rise0 = -1, last_start = 0;
    bit pv0 = 1'b0;

    // Observe outputs on the falling edge, away from the active edge.
    always @(negedge SYSCLK) begin
        if (if0.RX_VALID === 1'b1 && if0.RX_READY) got0.push_back(if0.RX_DATA);
        if (if1.RX_VALID === 1'b1 && if1.RX_READY) got1.push_back(if1.RX_DATA);
        if (if0.RX_VALID === 1'b1) begin
            vhi0++;
            if (!pv0) rise0 = cyc;
        end
        pv0 = (if0.RX_VALID === 1'b1);
        if (ferr0 === 1'b1) fe_n[0]++;
        if (perr0 === 1'b1) pe_n[0]++;
        if (ovr0  === 1'b1) ov_n[0]++;
        if (ferr1 === 1'b1) fe_n[1]++;
        if (perr1 === 1'b1) pe_n[1]++;
        if (ovr1  === 1'b1) ov_n[1]++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int w, input logic v);
        if (w == 0) rxd0 = v; else rxd1 = v;
        repeat (BIT_CYC) @(posedge SYSCLK);
        #1;
    endtask

    task automatic set_ready(input int w, input logic v);
        if (w == 0) if0.RX_READY = v; else if1.RX_READY = v;
        if (v) held[w] = 1'b0;
    endtask

    task automatic push_exp(input int w, input logic [7:0] b);
        if (w == 0) exp0.push_back(b); else exp1.push_back(b);
    endtask

    // Send one frame and predict its outcome from the frame contents alone.
    task automatic send(input int w, input logic [7:0] b, input logic pbit, input logic stopb);
        logic rdy;
        last_start = cyc;
        drive(w, 1'b0);
        for (int i = 0; i < 8; i++) drive(w, b[i]);
        if (w == 1) drive(w, pbit);
        drive(w, stopb);
        rdy = (w == 0) ? if0.RX_READY : if1.RX_READY;
        if (!stopb)                          efe[w]++;
        else if (w == 1 && pbit != (^b))     epe[w]++;
        else if (rdy)                        push_exp(w, b);
        else if (!held[w]) begin             push_exp(w, b); held[w] = 1'b1; end
        else                                 eov[w]++;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge SYSCLK);
        #1;
    endtask

    task automatic score(input string tag);
        check($sformatf("%s/n0", tag), got0.size(), exp0.size());
        for (int i = 0; i < exp0.size() && i < got0.size(); i++)
            check($sformatf("%s/b0[%0d]", tag, i), got0[i], exp0[i]);
        check($sformatf("%s/n1", tag), got1.size(), exp1.size());
        for (int i = 0; i < exp1.size() && i < got1.size(); i++)
            check($sformatf("%s/b1[%0d]", tag, i), got1[i], exp1[i]);
        for (int w = 0; w < 2; w++) begin
            check($sformatf("%s/ferr%0d", tag, w), fe_n[w], efe[w]);
            check($sformatf("%s/perr%0d", tag, w), pe_n[w], epe[w]);
            check($sformatf("%s/ovr%0d",  tag, w), ov_n[w], eov[w]);
            fe_n[w] = 0; pe_n[w] = 0; ov_n[w] = 0;
            efe[w] = 0;  epe[w] = 0;  eov[w] = 0;
        end
        got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
        vhi0 = 0; rise0 = -1;
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] bf;
        int w;
        logic pb, sb;

        if0.RX_READY = 1'b1;
        if1.RX_READY = 1'b1;
        wait_cyc(3);
        check("rst/data", if0.RX_DATA, 8'h00);
        check("rst/valid", if0.RX_VALID, 1'b0);
        check("rst/errs", {ferr0, perr0, ovr0}, 3'b000);
        check("rst/busy0", busy0, 1'b0);
        check("rst/busy1", busy1, 1'b0);
        SYSRESET = 1'b0;
        score("rst");
        wait_cyc(10);

        // Nominal byte, latency from start edge to RX_VALID rise.
        send(0, 8'h55, 1'b0, 1'b1);
        wait_cyc(5);
        check("s1/latency", rise0 - last_start - 1, 763);
        check("s1/vcycles", vhi0, 1);
        score("s1");

        // Short low glitch rejected at the start-bit midpoint.
        rxd0 = 1'b0;
        wait_cyc(30);
        check("glitch/busy_hi", busy0, 1'b1);
        rxd0 = 1'b1;
        wait_cyc(100);
        check("glitch/busy_lo", busy0, 1'b0);
        score("glitch");

        // Frame error, break held, then recovery.
        send(0, 8'hA3, 1'b0, 1'b0);
        check("ferr/busy_brk", busy0, 1'b1);
        wait_cyc(200);
        check("ferr/busy_hold", busy0, 1'b1);
        rxd0 = 1'b1;
        wait_cyc(4);
        check("ferr/busy_rel", busy0, 1'b0);
        wait_cyc(40);
        send(0, 8'h3C, 1'b0, 1'b1);
        wait_cyc(5);
        score("ferr");

        // Overrun with consumer stalled.
        set_ready(0, 1'b0);
        send(0, 8'h11, 1'b0, 1'b1);
        send(0, 8'h22, 1'b0, 1'b1);
        wait_cyc(5);
        check("ovr/data_held", if0.RX_DATA, 8'h11);
        check("ovr/valid_held", if0.RX_VALID, 1'b1);
        set_ready(0, 1'b1);
        wait_cyc(3);
        check("ovr/valid_clr", if0.RX_VALID, 1'b0);
        score("ovr");

        // Even parity: good, bad, and bad parity with bad stop (frame error wins).
        send(1, 8'h07, 1'b1, 1'b1);
        send(1, 8'h07, 1'b0, 1'b1);
        send(1, 8'h07, 1'b0, 1'b0);
        rxd1 = 1'b1;
        wait_cyc(10);
        check("par/busy1", busy1, 1'b0);
        score("par");

        // Reset in the middle of data bit 4, then a clean byte.
        bf = 8'hF0;
        drive(0, 1'b0);
        for (int i = 0; i < 4; i++) drive(0, bf[i]);
        rxd0 = bf[4];
        wait_cyc(40);
        SYSRESET = 1'b1;
        wait_cyc(1);
        SYSRESET = 1'b0;
        check("abort/busy", busy0, 1'b0);
        check("abort/valid", if0.RX_VALID, 1'b0);
        wait_cyc(39);
        for (int i = 5; i < 8; i++) drive(0, bf[i]);
        drive(0, 1'b1);
        send(0, 8'h81, 1'b0, 1'b1);
        wait_cyc(5);
        score("abort");

        // Randomized frames across both receivers.
        for (int n = 0; n < 16; n++) begin
            w  = int'($urandom_range(0, 1));
            b  = 8'($urandom);
            pb = ($urandom_range(0, 3) == 0) ? ~(^b) : (^b);
            sb = ($urandom_range(0, 7) != 0);
            send(w, b, pb, sb);
            if (!sb) begin
                if (w == 0) rxd0 = 1'b1; else rxd1 = 1'b1;
                wait_cyc(4);
            end
            wait_cyc(int'($urandom_range(0, 40)));
        end
        wait_cyc(5);
        score("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
